// File: rtl/spi_master_byte.sv
// rtl/spi_master_byte.sv - single-byte SPI mode-0 master with programmable SCLK rate
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   freq_control  SCLK half-period select: 00->2, 01->4, 10->8, 11->16 clk cycles
//   start         transfer request, accepted only when idle
//   tx_data       byte to send, captured on accepted start
//   miso          serial data from slave, sampled on SCLK rise
//   sclk          SPI clock, idle low
//   cs_bar        active-low chip select
//   mosi          serial data to slave, MSB first, updated on SCLK fall
//   rx_data       last received byte, held until next completion
//   rx_valid      one-cycle pulse when rx_data updates
//   busy          high from accepted start through completion
module spi_master_byte #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        freq_control,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso,
  output logic              sclk,
  output logic              cs_bar,
  output logic              mosi,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t            state_q, state_d;
  logic [3:0]        h_max_q, h_max_d;   // half-period minus one
  logic [3:0]        cnt_q, cnt_d;       // cycles elapsed in current half-period
  logic [BW-1:0]     fall_q, fall_d;     // falling edges produced so far
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic              sclk_d, cs_d, mosi_d, rx_valid_d, busy_d;
  logic [DATA_W-1:0] rx_data_d;
  logic              phase_end;

  assign phase_end = (cnt_q == h_max_q);

  always_comb begin
    state_d    = state_q;
    h_max_d    = h_max_q;
    cnt_d      = phase_end ? 4'd0 : cnt_q + 4'd1;
    fall_d     = fall_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    sclk_d     = sclk;
    cs_d       = cs_bar;
    mosi_d     = mosi;
    rx_data_d  = rx_data;
    rx_valid_d = 1'b0;
    busy_d     = busy;
    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (start) begin
          state_d = SETUP;
          tx_sh_d = tx_data;
          h_max_d = 4'((5'd2 << freq_control) - 5'd1);
          fall_d  = '0;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          mosi_d  = tx_data[DATA_W-1];
        end
      end
      SETUP: begin
        if (phase_end) begin
          state_d = XFER;
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
        end
      end
      XFER: begin
        if (phase_end) begin
          if (sclk) begin
            sclk_d  = 1'b0;
            tx_sh_d = tx_sh_q << 1;
            fall_d  = fall_q + 1'b1;
            if (fall_q == BW'(DATA_W - 1)) begin
              // last bit shifted out; mosi parks low for the hold phase
              mosi_d  = 1'b0;
              state_d = HOLD;
            end else begin
              mosi_d = tx_sh_q[DATA_W-2];
            end
          end else begin
            sclk_d  = 1'b1;
            rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
          end
        end
      end
      HOLD: begin
        if (phase_end) begin
          state_d    = IDLE;
          cs_d       = 1'b1;
          busy_d     = 1'b0;
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      h_max_q  <= 4'd1;
      cnt_q    <= 4'd0;
      fall_q   <= '0;
      tx_sh_q  <= '0;
      rx_sh_q  <= '0;
      sclk     <= 1'b0;
      cs_bar   <= 1'b1;
      mosi     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      h_max_q  <= h_max_d;
      cnt_q    <= cnt_d;
      fall_q   <= fall_d;
      tx_sh_q  <= tx_sh_d;
      rx_sh_q  <= rx_sh_d;
      sclk     <= sclk_d;
      cs_bar   <= cs_d;
      mosi     <= mosi_d;
      rx_data  <= rx_data_d;
      rx_valid <= rx_valid_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_spi_master_byte.sv
// tb/tb_spi_master_byte.sv - self-checking bench for spi_master_byte
module tb_spi_master_byte;

  logic       clk;
  logic       reset;
  logic [1:0] freq_control;
  logic       start;
  logic [7:0] tx_data;
  logic       miso;
  logic       sclk;
  logic       cs_bar;
  logic       mosi;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic       loop_en;
  logic [7:0] s_tx, s_sh, s_rx;
  logic [7:0] prev_rx;

  spi_master_byte #(.DATA_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .freq_control (freq_control),
    .start        (start),
    .tx_data      (tx_data),
    .miso         (miso),
    .sclk         (sclk),
    .cs_bar       (cs_bar),
    .mosi         (mosi),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode-0 slave: loads its byte on select, shifts out on SCLK fall, captures on SCLK rise
  assign miso = loop_en ? mosi : s_sh[7];

  always @(negedge cs_bar) begin
    s_sh = s_tx;
    s_rx = 8'h00;
  end
  always @(negedge sclk) if (!cs_bar) s_sh = {s_sh[6:0], 1'b0};
  always @(posedge sclk) if (!cs_bar) s_rx = {s_rx[6:0], mosi};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sclk"},     {7'd0, sclk},     8'h00);
    chk({tag, "_cs_bar"},   {7'd0, cs_bar},   8'h01);
    chk({tag, "_mosi"},     {7'd0, mosi},     8'h00);
    chk({tag, "_busy"},     {7'd0, busy},     8'h00);
    chk({tag, "_rx_valid"}, {7'd0, rx_valid}, 8'h00);
    chk({tag, "_rx_data"},  rx_data,          8'h00);
  endtask

  task automatic go(input logic [7:0] tx, input logic [1:0] fc);
    @(negedge clk);
    tx_data      = tx;
    freq_control = fc;
    start        = 1'b1;
  endtask

  // Reference timeline: t counts clk edges after the accepting edge.
  // SCLK is high in odd-numbered half-periods 1..15, mosi carries bit 7-n
  // during the n-th full period, and completion lands at 17 half-periods.
  task automatic mon(input string tag, input logic [1:0] fc, input logic [7:0] tx,
                     input logic [7:0] exp_rx, input bit keep, input bit perturb);
    int h;
    h = 2 << fc;
    for (int t = 0; t <= 17 * h; t++) begin
      logic e_sclk, e_cs, e_mosi, e_busy, e_rv;
      logic [7:0] e_rxd;
      int n;
      @(negedge clk);
      n      = t / (2 * h);
      e_cs   = (t < 17 * h) ? 1'b0 : 1'b1;
      e_busy = (t < 17 * h);
      e_sclk = (t >= h) && (t < 16 * h) && (((t / h) % 2) == 1);
      e_mosi = (t < 16 * h) ? tx[7 - n] : 1'b0;
      e_rv   = (t == 17 * h);
      e_rxd  = (t == 17 * h) ? exp_rx : prev_rx;
      chk($sformatf("%s_sclk_t%0d", tag, t),     {7'd0, sclk},     {7'd0, e_sclk});
      chk($sformatf("%s_cs_bar_t%0d", tag, t),   {7'd0, cs_bar},   {7'd0, e_cs});
      chk($sformatf("%s_mosi_t%0d", tag, t),     {7'd0, mosi},     {7'd0, e_mosi});
      chk($sformatf("%s_busy_t%0d", tag, t),     {7'd0, busy},     {7'd0, e_busy});
      chk($sformatf("%s_rx_valid_t%0d", tag, t), {7'd0, rx_valid}, {7'd0, e_rv});
      chk($sformatf("%s_rx_data_t%0d", tag, t),  rx_data,          e_rxd);
      if (t == 0 && !keep) start = 1'b0;
      if (perturb && t == 3 * h) begin
        start        = 1'b1;
        tx_data      = 8'h00;
        freq_control = ~fc;
      end
      if (perturb && t == 3 * h + 1) start = 1'b0;
    end
    prev_rx = exp_rx;
  endtask

  initial begin
    logic [7:0] rtx;
    logic [1:0] rfc;
    reset        = 1'b1;
    start        = 1'b0;
    tx_data      = 8'h00;
    freq_control = 2'b00;
    loop_en      = 1'b1;
    s_tx         = 8'h00;
    s_sh         = 8'h00;
    s_rx         = 8'h00;
    prev_rx      = 8'h00;

    // reset with random inputs
    #1;
    reset        = 1'b0;
    start        = 1'($urandom);
    tx_data      = 8'($urandom);
    freq_control = 2'($urandom);
    #2;
    chk_reset_vals("reset_async");
    repeat (3) @(negedge clk);
    chk_reset_vals("reset_held");
    start = 1'b0;
    reset = 1'b1;

    // basic loopback, H=2
    loop_en = 1'b1;
    go(8'hA5, 2'b00);
    mon("loop_a5", 2'b00, 8'hA5, 8'hA5, 1'b0, 1'b0);

    // slave returns 0x3C, H=16
    loop_en = 1'b0;
    s_tx    = 8'h3C;
    go(8'hFF, 2'b11);
    mon("slave_3c", 2'b11, 8'hFF, 8'h3C, 1'b0, 1'b0);
    chk("slave_got_ff", s_rx, 8'hFF);

    // start / tx_data / freq_control disturbed mid-transfer
    loop_en = 1'b1;
    go(8'h81, 2'b01);
    mon("busy_81", 2'b01, 8'h81, 8'h81, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("after_busy_rv_%0d", i),   {7'd0, rx_valid}, 8'h00);
      chk($sformatf("after_busy_busy_%0d", i), {7'd0, busy},     8'h00);
    end

    // back-to-back with start held high
    go(8'h5A, 2'b00);
    mon("b2b_first", 2'b00, 8'h5A, 8'h5A, 1'b1, 1'b0);
    mon("b2b_second", 2'b00, 8'h5A, 8'h5A, 1'b0, 1'b0);

    // reset after the 3rd SCLK rise (t = 5H), asserted between clock edges
    go(8'($urandom), 2'b00);
    for (int t = 0; t <= 5 * 2 + 1; t++) begin
      @(negedge clk);
      if (t == 0) start = 1'b0;
    end
    chk("pre_reset_busy", {7'd0, busy}, 8'h01);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("midreset_async");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("midreset_rv_%0d", i), {7'd0, rx_valid}, 8'h00);
    end
    reset   = 1'b1;
    prev_rx = 8'h00;
    @(negedge clk);
    chk_reset_vals("after_release");
    go(8'hC3, 2'b00);
    mon("after_reset_c3", 2'b00, 8'hC3, 8'hC3, 1'b0, 1'b0);

    // randomized transfers against the slave or loopback
    for (int i = 0; i < 6; i++) begin
      rtx     = 8'($urandom);
      rfc     = 2'($urandom);
      loop_en = 1'($urandom);
      s_tx    = 8'($urandom);
      go(rtx, rfc);
      mon($sformatf("rand%0d", i), rfc, rtx, loop_en ? rtx : s_tx, 1'b0, 1'b0);
      if (!loop_en) chk($sformatf("rand%0d_slave_rx", i), s_rx, rtx);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master_byte.md
# spi_master_byte

Single-byte SPI mode-0 master (initiator) that drives `sclk`, `cs_bar` and `mosi` and samples `miso`. It is the controller-side counterpart of the SPI slave port in `uart_spi_top`. It lets the design exercise the slave over a loopback, or talk to an external SPI device. One 8-bit full-duplex transfer runs per `start` request, MSB first, with a programmable SCLK rate chosen by the same 2-bit `freq_control` encoding used elsewhere in the design.

## Interface
Parameters:
- `DATA_W`, default 8: transfer width in bits. Only 8 is verified.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `freq_control`  in  2  SCLK half-period select: 00→2, 01→4, 10→8, 11→16 `clk` cycles (H).
- `start`  in  1  transfer request, sampled when idle.
- `tx_data`  in  8  byte to transmit; latched on accepted `start`.
- `miso`  in  1  serial data from slave.
- `sclk`  out  1  SPI clock, idle low (CPOL=0).
- `cs_bar`  out  1  active-low chip select.
- `mosi`  out  1  serial data to slave.
- `rx_data`  out  8  last received byte; held until next completion.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `busy`  out  1  high from accepted `start` through completion.

## Operation
- Reset values: `sclk`=0, `cs_bar`=1, `mosi`=0, `rx_data`=0x00, `rx_valid`=0, `busy`=0, state IDLE.
- Reset is asynchronous. Asserting it mid-transfer forces all outputs to their reset values immediately and abandons the transfer, with no `rx_valid`.
- States: IDLE → SETUP → XFER → HOLD → IDLE.
- **IDLE:** `start`=1 is accepted. It latches `tx_data` into the shift register, latches H from `freq_control`, and clears the bit counter. The next state is SETUP, with `cs_bar`←0, `busy`←1 and `mosi`←`tx_data[7]`.
- **SETUP:** lasts H cycles, then goes to XFER with `sclk`←1 (first rising edge).
- **XFER:** `sclk` toggles every H cycles, giving 16 edges total (8 rising, 8 falling).
  - Rising edge: `miso` is shifted into the receive register LSB-first-in, so the first-sampled bit ends up as MSB.
  - Falling edge: `mosi` advances to the next tx bit.
  - After the 8th falling edge `mosi` is don't-care and driven 0, and the state moves to HOLD.
- **HOLD:** lasts H cycles with `sclk`=0. It then returns to IDLE, where `cs_bar`←1, `busy`←0, `rx_data`←receive register and `rx_valid`←1 for exactly one cycle.
- `start` while `busy`=1 is ignored; nothing is queued.
- `freq_control` and `tx_data` changes during a transfer have no effect.
- `miso` is sampled directly, with no synchronizer. It is stable because the slave changes it on the falling edge, H cycles before the sample.

## Timing
- Let `start` be sampled at edge k.
- `cs_bar` falls, `busy` rises and `mosi`=bit7, all visible after edge k+1.
- The first `sclk` rise is at edge k+1+H. The n-th rise (n=1..8) is at k+1+(2n−1)H, and the n-th fall is at k+1+2nH.
- The `cs_bar` rise, the `rx_valid` pulse and the `busy` fall all occur at edge k+1+17H.
- Total latency from `start` to `rx_valid` is 17H+1 cycles: 35 for H=2 and 273 for H=16.
- Back-to-back: a `start` held high is re-accepted at edge k+2+17H. `cs_bar` therefore stays high for exactly 1 cycle between transfers.
- `sclk` duty cycle is exactly 50%, with period 2H.
- Setup margin: `mosi` is stable at least H cycles before each `sclk` rise.

## Test plan
- **Reset values:** assert `reset`=0 with random inputs → `sclk`=0, `cs_bar`=1, `mosi`=0, `busy`=0, `rx_valid`=0, `rx_data`=0x00.
- **Basic loopback:** `miso` tied to `mosi`, `freq_control`=00, `tx_data`=0xA5, `start` for 1 cycle → `mosi` sequence 1,0,1,0,0,1,0,1 on the rises. `rx_valid` pulses exactly 35 cycles after `start` with `rx_data`=0xA5, and `cs_bar` stays low for 34 cycles.
- **Slave model:** mode-0 slave returns 0x3C, `freq_control`=11, `tx_data`=0xFF → `sclk` period of 32 cycles, `rx_data`=0x3C at 273 cycles, and the slave receives 0xFF.
- **Busy and ignored inputs:** `start` re-pulsed with `tx_data`=0x00 and `freq_control` changed mid-transfer (first transfer 0x81, H=4) → exactly one `rx_valid`, the `mosi` pattern matches 0x81, and the `sclk` period stays 8.
- **Back-to-back:** `start` held high, loopback, 0x5A → second transfer begins with `cs_bar` high for exactly 1 cycle, and both completions report 0x5A.
- **Mid-transfer reset:** `reset` asserted after the 3rd `sclk` rise, then released → outputs return to reset values asynchronously with no `rx_valid`, and the next `start` with 0xC3 completes normally.
